bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the granted-cycle count without mem_ready that forces an error termination (0 disables it).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, meaning the read data returned on a timed-out transfer.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge only.
REQ-004 SHALL have ports: nreset  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: m0_valid, m1_valid  in  1  master request; held until the matching ready.
REQ-006 SHALL have ports: m0_addr, m1_addr  in  32  byte address.
REQ-007 SHALL have ports: m0_wdata, m1_wdata  in  32  write data.
REQ-008 SHALL have ports: m0_wstrb, m1_wstrb  in  4  byte strobes; all-zero means a read.
REQ-009 SHALL have ports: m0_ready, m1_ready  out  1  single-cycle transfer completion.
REQ-010 SHALL have ports: m0_rdata, m1_rdata  out  32  read data, valid only with ready.
REQ-011 SHALL have ports: mem_valid  out  1, mem_addr  out  32, mem_wdata  out  32, mem_wstrb  out  4, mem_ready  in  1, mem_rdata  in  32, forming the shared slave bus.
REQ-012 SHALL have ports: grant  out  2  one-hot owner {m1,m0}; 2'b00 when idle.
REQ-013 SHALL have ports: err  out  1  sticky timeout flag.
REQ-014 SHALL have ports: err_clr  in  1  clears err.

Function
REQ-015 SHALL implement FSM states IDLE, GNT0 and GNT1, plus a 1-bit last-owner register and a timeout counter of width clog2(TIMEOUT_CYCLES+1).
REQ-016 In IDLE with exactly one valid, the FSM SHALL enter that master's GNT state at the next edge.
REQ-017 In IDLE with both valid, the FSM SHALL grant the master that is not last-owner (round robin).
REQ-018 In a GNT state, the slave bus SHALL combinationally carry the owner's addr, wdata and wstrb, with mem_valid = owner valid; mem_valid SHALL be 0 in IDLE.
REQ-019 In GNT state, owner ready SHALL equal mem_ready & mem_valid, and owner rdata SHALL equal mem_rdata (zero-latency pass-through).
REQ-020 The non-owner's ready SHALL be 0 at all times, and its rdata SHALL be 0.
REQ-021 On owner ready, the FSM SHALL return to IDLE at the next edge, set last-owner to the owner and clear the counter; minimum spacing between grants is therefore 1 idle cycle.
REQ-022 A new arbitration SHALL occur only in IDLE; no preemption of a granted master.
REQ-023 If the owner drops valid before ready (protocol violation), the FSM SHALL return to IDLE with no ready and leave last-owner unchanged.
REQ-024 The counter SHALL increment each GNT cycle in which mem_ready is 0, saturating and never wrapping.
REQ-025 When TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES, in that cycle the arbiter SHALL force mem_valid 0, assert owner ready for 1 cycle with rdata = ERR_RDATA (also for writes), set err, and then return to IDLE.
REQ-026 If mem_ready arrives in the same cycle the count reaches the limit, the normal completion SHALL take priority and err SHALL NOT be set.
REQ-027 err SHALL be set by a timeout and cleared by err_clr; a simultaneous set and clear SHALL leave err at 1.
REQ-028 The grant output SHALL be registered and SHALL reflect the current FSM state.

Reset
REQ-029 While nreset is 0, asynchronously: state IDLE, last-owner = 1 (m0 wins the first contention), counter 0, err 0, grant 00, and mem_valid, m0_ready and m1_ready all 0.
REQ-030 A reset mid-transfer SHALL abandon the transfer with no ready pulse; masters re-request after reset.

Verification
REQ-031 Scenario: both valid in the first cycle after reset -> m0 granted first, m1 granted second; grant sequences 01, 00, 10.
REQ-032 Scenario: m0 writes 32'h12345678 with wstrb 4'hF to address 0x100 while m1 idle -> mem bus mirrors the write, m0_ready asserts with mem_ready, and m1_ready stays 0 throughout.
REQ-033 Scenario: both masters requesting continuously for 8 transfers -> strict alternation, 4 completions each.
REQ-034 Scenario: TIMEOUT_CYCLES=4, slave never readies, m1 reads -> m1_ready on the 5th granted cycle with rdata DEADBEEF, err=1, and err=0 after an err_clr pulse.
REQ-035 Scenario: mem_ready arrives on the cycle the timeout triggers -> normal rdata is returned and err stays 0.
REQ-036 Scenario: nreset asserted while in GNT1 awaiting ready -> outputs at reset values immediately, with no m1_ready pulse.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single shared slave bus.
// Owner signals pass through combinationally; a granted transfer that stalls too long is error-terminated.
module bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant,
   output logic        err,
   input  logic        err_clr
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

   state_t        state;
   logic          last_owner;
   logic [CW-1:0] cnt;

   logic        granted, owner_m1, own_valid, tmo_hit, own_ready;
   logic [31:0] own_rdata;

   always_comb begin
      granted   = (state != IDLE);
      owner_m1  = (state == GNT1);
      own_valid = granted & (owner_m1 ? m1_valid : m0_valid);
      // A slave answering on the limit cycle wins over the timeout.
      tmo_hit   = (TIMEOUT_CYCLES != 0) && own_valid &&
                  (cnt == CW'(TIMEOUT_CYCLES)) && !mem_ready;
      mem_valid = own_valid & ~tmo_hit;
      mem_addr  = owner_m1 ? m1_addr  : m0_addr;
      mem_wdata = owner_m1 ? m1_wdata : m0_wdata;
      mem_wstrb = owner_m1 ? m1_wstrb : m0_wstrb;
      own_ready = (mem_ready & mem_valid) | tmo_hit;
      own_rdata = tmo_hit ? ERR_RDATA : mem_rdata;
      m0_ready  = (state == GNT0) & own_ready;
      m1_ready  = (state == GNT1) & own_ready;
      m0_rdata  = (state == GNT0) ? own_rdata : 32'h0;
      m1_rdata  = (state == GNT1) ? own_rdata : 32'h0;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_owner <= 1'b1;
         cnt        <= '0;
         err        <= 1'b0;
      end else begin
         if (tmo_hit)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (m0_valid && (!m1_valid || last_owner)) begin
                  state <= GNT0;
                  grant <= 2'b01;
               end else if (m1_valid) begin
                  state <= GNT1;
                  grant <= 2'b10;
               end
            end
            GNT0, GNT1: begin
               if (!own_valid) begin
                  // Owner withdrew mid-transfer: drop it without touching fairness.
                  state <= IDLE;
                  grant <= 2'b00;
                  cnt   <= '0;
               end else if (own_ready) begin
                  state      <= IDLE;
                  grant      <= 2'b00;
                  last_owner <= owner_m1;
                  cnt        <= '0;
               end else if (!mem_ready && cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
